// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: FSM state encodings and
// read-owner port IDs used to steer returning read data.
package ram_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE     = 1'b0,
    ARB_LD_BURST = 1'b1
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter used for the arbiter's starvation, burst and
// statistics counters. Asserting i_clr together with i_inc restarts the
// count at 1 (the clearing event is itself the first counted event).
module arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // Count events, restart on clear, and hold once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? ONE_V : '0;
    end else if (i_inc && (r_count != LIMIT_V)) begin
      r_count <= r_count + ONE_V;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single data RAM between the CPU MEM stage (port 0)
// and the external program/data loader (port 1). The CPU has priority; a
// starvation guard forces a loader grant after STARVE_LIMIT CPU wins, and
// a loader burst lock holds the RAM for the loader until ld_last or until
// BURST_MAX cycles have elapsed. Read data is a passthrough of ram_rdata,
// qualified per port by a registered rvalid.
// Optional build macro RAM_ARB_STATS_EN adds the cpu_wait_cnt and
// ld_grant_cnt statistics outputs.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AWIDTH       = 8,
  parameter int DWIDTH       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 16
) (
  input  logic              clk,
  input  logic              ext_rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DWIDTH-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_wr,
  input  logic              ld_last,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DWIDTH-1:0] ld_rdata,
  output logic              ram_rd,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic              ram_wr,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_wait_cnt,
  output logic [15:0]       ld_grant_cnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_V = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_V  = BW'(BURST_MAX);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_rd_valid;
  logic              r_rd_owner;
  logic              w_cpu_req;
  logic              w_ld_req;
  logic              w_cpu_gnt;
  logic              w_ld_gnt;
  logic              w_burst_start;
  logic              w_rd_issue;
  logic [SW-1:0]     w_starve_cnt;
  logic [BW-1:0]     w_burst_cnt;
  logic [AWIDTH-1:0] w_addr;

  // Requests are masked while reset is held so nothing reaches the RAM
  assign w_cpu_req = cpu_req & ext_rst;
  assign w_ld_req  = ld_req & ext_rst;

  // Grant decision and next state: CPU priority in IDLE, loader owns the RAM in a burst
  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_ld_gnt     = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        w_ld_gnt  = w_ld_req & (~w_cpu_req | (w_starve_cnt == STARVE_V));
        w_cpu_gnt = w_cpu_req & ~w_ld_gnt;
        if (w_ld_gnt && !ld_last) begin
          w_next_state = ARB_LD_BURST;
        end
      end
      ARB_LD_BURST: begin
        w_ld_gnt = w_ld_req;
        if (w_burst_cnt == BURST_V) begin
          w_next_state = ARB_IDLE;
        end else if (w_ld_gnt && ld_last) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge ext_rst) begin
    if (!ext_rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign w_burst_start = (r_state == ARB_IDLE) & w_ld_gnt & ~ld_last;

  arb_sat_counter #(
    .WIDTH (SW),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst_n   (ext_rst),
    .i_inc   (w_cpu_gnt & w_ld_req),
    .i_clr   (w_ld_gnt | ~w_ld_req),
    .o_count (w_starve_cnt)
  );

  arb_sat_counter #(
    .WIDTH (BW),
    .LIMIT (BURST_MAX)
  ) u_burst_cnt (
    .clk     (clk),
    .rst_n   (ext_rst),
    .i_inc   ((r_state == ARB_LD_BURST) | w_burst_start),
    .i_clr   (w_burst_start),
    .o_count (w_burst_cnt)
  );

  assign w_rd_issue = (w_cpu_gnt & ~cpu_wr) | (w_ld_gnt & ~ld_wr);

  // Remember which port issued the read so its rvalid fires on the next cycle
  always_ff @(posedge clk or negedge ext_rst) begin
    if (!ext_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_owner <= PORT_CPU;
    end else begin
      r_rd_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_owner <= w_ld_gnt ? PORT_LD : PORT_CPU;
      end
    end
  end

  assign w_addr = w_cpu_gnt ? cpu_addr : (w_ld_gnt ? ld_addr : '0);

  assign cpu_gnt    = w_cpu_gnt;
  assign ld_gnt     = w_ld_gnt;
  assign ram_rd     = w_rd_issue;
  assign ram_wr     = (w_cpu_gnt & cpu_wr) | (w_ld_gnt & ld_wr);
  assign ram_raddr  = w_addr;
  assign ram_waddr  = w_addr;
  assign ram_wdata  = w_cpu_gnt ? cpu_wdata : (w_ld_gnt ? ld_wdata : '0);
  assign cpu_rvalid = r_rd_valid & (r_rd_owner == PORT_CPU);
  assign ld_rvalid  = r_rd_valid & (r_rd_owner == PORT_LD);
  assign cpu_rdata  = ram_rdata;
  assign ld_rdata   = ram_rdata;

`ifdef RAM_ARB_STATS_EN
  arb_sat_counter #(
    .WIDTH (16),
    .LIMIT (65535)
  ) u_cpu_wait_cnt (
    .clk     (clk),
    .rst_n   (ext_rst),
    .i_inc   (w_cpu_req & ~w_cpu_gnt),
    .i_clr   (1'b0),
    .o_count (cpu_wait_cnt)
  );

  arb_sat_counter #(
    .WIDTH (16),
    .LIMIT (65535)
  ) u_ld_grant_cnt (
    .clk     (clk),
    .rst_n   (ext_rst),
    .i_inc   (w_ld_gnt),
    .i_clr   (1'b0),
    .o_count (ld_grant_cnt)
  );
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural 1-cycle RAM, per-cycle grant
// expectations, and a scoreboard of expected read data popped as rvalid
// returns. Stats outputs are checked when RAM_ARB_STATS_EN is defined.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } sbItem_t;

  logic          clk = 1'b0;
  logic          ext_rst;
  logic          cpu_req, cpu_wr, ld_req, ld_wr, ld_last;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic          cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid;
  logic [DW-1:0] cpu_rdata, ld_rdata;
  logic          ram_rd, ram_wr;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   cpu_wait_cnt, ld_grant_cnt;
`endif

  logic [DW-1:0] ramMem [0:255];
  logic [DW-1:0] refMem [0:255];
  sbItem_t       sbQueue [$];
  int            assertionCount = 0;
  int            failCount = 0;
  int            expWaitCnt = 0;
  int            expLdGrantCnt = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .AWIDTH       (AW),
    .DWIDTH       (DW),
    .STARVE_LIMIT (4),
    .BURST_MAX    (16)
  ) dut (
    .clk        (clk),
    .ext_rst    (ext_rst),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ld_req     (ld_req),
    .ld_wr      (ld_wr),
    .ld_last    (ld_last),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_rdata   (ld_rdata),
    .ram_rd     (ram_rd),
    .ram_raddr  (ram_raddr),
    .ram_wr     (ram_wr),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
`ifdef RAM_ARB_STATS_EN
    ,
    .cpu_wait_cnt (cpu_wait_cnt),
    .ld_grant_cnt (ld_grant_cnt)
`endif
  );

  // Behavioural RAM: writes land on the clock edge, reads return one cycle later
  always @(posedge clk) begin
    if (ram_wr) ramMem[ram_waddr] <= ram_wdata;
    if (ram_rd) ram_rdata <= ramMem[ram_raddr];
  end

  function automatic logic [DW-1:0] initWord(input int i);
    logic [7:0] lo;
    lo = 8'(i);
    if (i == 16) return 16'hBEEF;
    return {lo ^ 8'h5A, lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertionCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // One arbitration cycle: drive both ports, check grants and strobes, then check returning read data
  task automatic applyStimulus(
    input logic cReq, input logic cWr, input logic [AW-1:0] cAddr, input logic [DW-1:0] cWdata,
    input logic lReq, input logic lWr, input logic lLast, input logic [AW-1:0] lAddr,
    input logic [DW-1:0] lWdata, input logic expCpu, input logic expLd);
    logic          expRd, expWr;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [DW-1:0] obsData;
    sbItem_t       item;
    cpu_req = cReq; cpu_wr = cWr; cpu_addr = cAddr; cpu_wdata = cWdata;
    ld_req = lReq; ld_wr = lWr; ld_last = lLast; ld_addr = lAddr; ld_wdata = lWdata;
    #1;
    expRd    = (expCpu & ~cWr) | (expLd & ~lWr);
    expWr    = (expCpu & cWr) | (expLd & lWr);
    expAddr  = expCpu ? cAddr : lAddr;
    expWdata = expCpu ? cWdata : lWdata;
    checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(expCpu));
    checkOutput("ld_gnt", 32'(ld_gnt), 32'(expLd));
    checkOutput("ram_rd", 32'(ram_rd), 32'(expRd));
    checkOutput("ram_wr", 32'(ram_wr), 32'(expWr));
    if (expRd) checkOutput("ram_raddr", 32'(ram_raddr), 32'(expAddr));
    if (expWr) begin
      checkOutput("ram_waddr", 32'(ram_waddr), 32'(expAddr));
      checkOutput("ram_wdata", 32'(ram_wdata), 32'(expWdata));
    end
    if (expCpu & ~cWr) sbQueue.push_back('{port: 1'b0, data: refMem[cAddr]});
    if (expLd & ~lWr)  sbQueue.push_back('{port: 1'b1, data: refMem[lAddr]});
    if (expCpu & cWr)  refMem[cAddr] = cWdata;
    if (expLd & lWr)   refMem[lAddr] = lWdata;
    if (cReq & ~expCpu) expWaitCnt++;
    if (expLd) expLdGrantCnt++;
    @(posedge clk);
    #1;
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(expCpu & ~cWr));
    checkOutput("ld_rvalid", 32'(ld_rvalid), 32'(expLd & ~lWr));
    if (cpu_rvalid || ld_rvalid) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        item    = sbQueue.pop_front();
        obsData = ld_rvalid ? ld_rdata : cpu_rdata;
        checkOutput("sb_port", 32'(ld_rvalid), 32'(item.port));
        checkOutput("sb_rdata", 32'(obsData), 32'(item.data));
      end
    end
    @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'd0);
    checkOutput({tag, "_ld_gnt"}, 32'(ld_gnt), 32'd0);
    checkOutput({tag, "_ram_rd"}, 32'(ram_rd), 32'd0);
    checkOutput({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
    checkOutput({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    checkOutput({tag, "_ld_rvalid"}, 32'(ld_rvalid), 32'd0);
`ifdef RAM_ARB_STATS_EN
    checkOutput({tag, "_cpu_wait_cnt"}, 32'(cpu_wait_cnt), 32'd0);
    checkOutput({tag, "_ld_grant_cnt"}, 32'(ld_grant_cnt), 32'd0);
`endif
  endtask

  task automatic checkStats(input string tag);
`ifdef RAM_ARB_STATS_EN
    checkOutput({tag, "_cpu_wait_cnt"}, 32'(cpu_wait_cnt), 32'(expWaitCnt));
    checkOutput({tag, "_ld_grant_cnt"}, 32'(ld_grant_cnt), 32'(expLdGrantCnt));
`else
    $display("[TB] %s: stats outputs not built", tag);
`endif
  endtask

  // Main sequence: reset, CPU read, starvation, bursts, alternating reads, reset mid-burst
  initial begin
    for (int i = 0; i < 256; i++) begin
      ramMem[i] = initWord(i);
      refMem[i] = initWord(i);
    end
    ext_rst = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10; cpu_wdata = '0;
    ld_req = 1'b1; ld_wr = 1'b0; ld_last = 1'b0; ld_addr = 8'h11; ld_wdata = '0;
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_raddr", 32'(ram_raddr), 32'd0);
    checkOutput("reset_waddr", 32'(ram_waddr), 32'd0);
    checkOutput("reset_wdata", 32'(ram_wdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset_held");
    @(negedge clk);
    cpu_req = 1'b0; ld_req = 1'b0;
    ext_rst = 1'b1;

    $display("[TB] CPU-only read of 0x10");
    applyStimulus(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 0);
    applyStimulus(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0);

    $display("[TB] Starvation guard");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 8'(8'h20 + i), 16'h0, 1, 1, 1, 8'h30, 16'h1234, 1, 0);
    applyStimulus(1, 0, 8'h24, 16'h0, 1, 1, 1, 8'h30, 16'h1234, 0, 1);
    applyStimulus(1, 0, 8'h24, 16'h0, 1, 1, 1, 8'h31, 16'h5678, 1, 0);
    applyStimulus(1, 0, 8'h30, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 0);

    $display("[TB] Loader burst of three writes");
    applyStimulus(0, 0, 8'h10, 16'h0, 1, 1, 0, 8'h40, 16'h4000, 0, 1);
    applyStimulus(1, 0, 8'h10, 16'h0, 1, 1, 0, 8'h41, 16'h4001, 0, 1);
    applyStimulus(1, 0, 8'h10, 16'h0, 1, 1, 1, 8'h42, 16'h4002, 0, 1);
    applyStimulus(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 0);
    applyStimulus(0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h41, 16'h0, 0, 1);

    $display("[TB] Loader burst without ld_last");
    applyStimulus(0, 0, 8'h10, 16'h0, 1, 0, 0, 8'h50, 16'h0, 0, 1);
    for (int i = 1; i <= 16; i++)
      applyStimulus(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'(8'h50 + i), 16'h0, 0, 1);
    applyStimulus(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h61, 16'h0, 1, 0);
    applyStimulus(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0);

    $display("[TB] Alternating back-to-back reads");
    applyStimulus(1, 0, 8'h61, 16'h0, 0, 0, 1, 8'h00, 16'h0, 1, 0);
    applyStimulus(0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h62, 16'h0, 0, 1);
    applyStimulus(1, 0, 8'h63, 16'h0, 0, 0, 1, 8'h00, 16'h0, 1, 0);
    applyStimulus(0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h64, 16'h0, 0, 1);
    checkStats("stats");

    $display("[TB] Reset during loader burst");
    applyStimulus(0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h70, 16'h0, 0, 1);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10;
    ld_req = 1'b1; ld_wr = 1'b0; ld_last = 1'b0; ld_addr = 8'h71;
    #1;
    checkOutput("burst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("burst_ld_gnt", 32'(ld_gnt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_ld_rvalid", 32'(ld_rvalid), 32'd1);
    checkOutput("pre_rst_ld_rdata", 32'(ld_rdata), 32'(refMem[8'h71]));
    ext_rst = 1'b0;
    expWaitCnt = 0;
    expLdGrantCnt = 0;
    #1;
    checkIdleOutputs("mid_rst");
    @(posedge clk);
    #1;
    checkIdleOutputs("mid_rst_held");
    @(negedge clk);
    ext_rst = 1'b1;
    applyStimulus(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h72, 16'h0, 1, 0);
    applyStimulus(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0);
    checkStats("post_rst_stats");

    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
